uart_im_loader: RTL and testbench

- Program loader for the single-cycle RISC-V core. It is the writer side of the instruction-memory read port.
- Receives a framed program image over a UART RX line (8N1) and writes 32-bit words into instruction memory.
- Holds the core in reset while loading and releases it when the load completes cleanly.
- Sits between the board RX pin, the IM write port and the core reset.

---
 rtl/uart_im_loader.sv | 328 ++++++++++++++++++++++++++++++++
 tb/tb_uart_im_loader.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_im_loader.sv
`default_nettype none
// ============================================================================
// Module   : uart_im_loader
// Purpose  : Program loader for the single-cycle RISC-V core. Receives a
//            framed program image over an 8N1 UART line and writes 32-bit
//            words into instruction memory. The core is held in reset while
//            a load runs and is released only after a clean load.
//            Frame: A5 | N[7:0] | N[15:8] | N x 4 bytes (LE) | XOR checksum.
// Ports    : clk, rst_n      - system clock / async active-low reset
//            rx              - UART serial input (idles high)
//            start           - level switch, rising edge arms a load
//            im_we/im_addr/im_wdata - IM write port
//            cpu_rst_n       - core reset (active low)
//            busy/done/err   - load status (done/err sticky)
// Options  : `define UART_IM_LOADER_TIMEOUT_EN adds an inter-byte watchdog
//            (20 bit times) in LEN0/LEN1/DATA/CSUM.
// Revision : 1.0 - initial release
// ============================================================================
module uart_im_loader #(
   parameter int CLK_HZ      = 50000000,
   parameter int BAUD        = 115200,
   parameter int ADDR_W      = 8,
   parameter int DEPTH_WORDS = 256      // must be <= 2**ADDR_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              rx,
   input  logic              start,
   output logic              im_we,
   output logic [ADDR_W-1:0] im_addr,
   output logic [31:0]       im_wdata,
   output logic              cpu_rst_n,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
   localparam int HALF_BIT     = CLKS_PER_BIT / 2;
   localparam int BIT_CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [7:0] SYNC_BYTE = 8'hA5;

   typedef enum logic [1:0] {
      RX_IDLE  = 2'd0,
      RX_START = 2'd1,
      RX_DATA  = 2'd2,
      RX_STOP  = 2'd3
   } rx_state_t;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_SYNC = 3'd1,
      ST_LEN0 = 3'd2,
      ST_LEN1 = 3'd3,
      ST_DATA = 3'd4,
      ST_CSUM = 3'd5,
      ST_DONE = 3'd6,
      ST_ERR  = 3'd7
   } state_t;

   // ---------------------------------------------------------------- inputs
   logic rx_meta_q, rx_sync_q, rx_prev_q;
   logic rx_meta_d, rx_sync_d, rx_prev_d;
   logic start_meta_q, start_sync_q, start_prev_q;
   logic start_meta_d, start_sync_d, start_prev_d;
   logic start_rise;

   // ---------------------------------------------------------------- sampler
   rx_state_t            rx_state_q, rx_state_d;
   logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
   logic [2:0]           bit_idx_q, bit_idx_d;
   logic [7:0]           shift_q, shift_d;
   logic                 byte_valid_q, byte_valid_d;
   logic                 frame_err_q, frame_err_d;

   // ---------------------------------------------------------------- loader
   state_t            state_q, state_d;
   logic [15:0]       len_q, len_d;
   logic [1:0]        byte_idx_q, byte_idx_d;
   logic [7:0]        csum_q, csum_d;
   logic              im_we_q, im_we_d;
   logic [ADDR_W-1:0] im_addr_q, im_addr_d;
   logic [31:0]       im_wdata_q, im_wdata_d;
   logic              cpu_rst_n_q, cpu_rst_n_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic [15:0]       len_new;
   logic              last_word;

`ifdef UART_IM_LOADER_TIMEOUT_EN
   localparam int TO_CYCLES = 20 * CLKS_PER_BIT;
   localparam int WD_W      = $clog2(TO_CYCLES + 1);
   logic [WD_W-1:0] wdog_q, wdog_d;
   logic            timed;
`endif

   // Synchronisers and edge detectors
   always_comb begin
      rx_meta_d    = rx;
      rx_sync_d    = rx_meta_q;
      rx_prev_d    = rx_sync_q;
      start_meta_d = start;
      start_sync_d = start_meta_q;
      start_prev_d = start_sync_q;
   end

   assign start_rise = start_sync_q & ~start_prev_q;

   // UART 8N1 sampler
   always_comb begin
      rx_state_d   = rx_state_q;
      bit_cnt_d    = bit_cnt_q;
      bit_idx_d    = bit_idx_q;
      shift_d      = shift_q;
      byte_valid_d = 1'b0;
      frame_err_d  = 1'b0;
      case (rx_state_q)
         RX_IDLE: begin
            if (rx_prev_q && !rx_sync_q) begin
               rx_state_d = RX_START;
               bit_cnt_d  = '0;
            end
         end
         RX_START: begin
            // Mid-start-bit re-check: a line back high here was a glitch.
            if (bit_cnt_q == BIT_CNT_W'(HALF_BIT - 1)) begin
               bit_cnt_d = '0;
               bit_idx_d = '0;
               rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
            end else begin
               bit_cnt_d = bit_cnt_q + 1'b1;
            end
         end
         RX_DATA: begin
            if (bit_cnt_q == BIT_CNT_W'(CLKS_PER_BIT - 1)) begin
               bit_cnt_d = '0;
               shift_d   = {rx_sync_q, shift_q[7:1]};   // LSB first
               if (bit_idx_q == 3'd7) begin
                  rx_state_d = RX_STOP;
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
               end
            end else begin
               bit_cnt_d = bit_cnt_q + 1'b1;
            end
         end
         RX_STOP: begin
            if (bit_cnt_q == BIT_CNT_W'(CLKS_PER_BIT - 1)) begin
               bit_cnt_d    = '0;
               rx_state_d   = RX_IDLE;
               byte_valid_d = rx_sync_q;
               frame_err_d  = ~rx_sync_q;
            end else begin
               bit_cnt_d = bit_cnt_q + 1'b1;
            end
         end
         default: rx_state_d = RX_IDLE;
      endcase
   end

   assign len_new   = {shift_q, len_q[7:0]};
   assign last_word = ((32'(im_addr_q) + 32'd1) == 32'(len_q));

   // Loader FSM
   always_comb begin
      state_d     = state_q;
      len_d       = len_q;
      byte_idx_d  = byte_idx_q;
      csum_d      = csum_q;
      im_we_d     = 1'b0;
      im_addr_d   = im_addr_q;
      im_wdata_d  = im_wdata_q;
      cpu_rst_n_d = cpu_rst_n_q;
      busy_d      = busy_q;
      done_d      = done_q;
      err_d       = err_q;
`ifdef UART_IM_LOADER_TIMEOUT_EN
      wdog_d      = '0;
      timed       = 1'b0;
`endif

      if (frame_err_q && (state_q != ST_IDLE) && (state_q != ST_DONE) &&
          (state_q != ST_ERR)) begin
         state_d = ST_ERR;
      end else begin
         case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
               if (start_rise) state_d = ST_SYNC;
            end
            ST_SYNC: begin
               if (byte_valid_q && (shift_q == SYNC_BYTE)) state_d = ST_LEN0;
            end
            ST_LEN0: begin
               if (byte_valid_q) begin
                  len_d[7:0] = shift_q;
                  state_d    = ST_LEN1;
               end
            end
            ST_LEN1: begin
               if (byte_valid_q) begin
                  len_d      = len_new;
                  byte_idx_d = 2'd0;
                  if (32'(len_new) > DEPTH_WORDS) state_d = ST_ERR;
                  else if (len_new == 16'd0)      state_d = ST_CSUM;
                  else                            state_d = ST_DATA;
               end
            end
            ST_DATA: begin
               // The strobe cycle decides whether this was the final word;
               // the address only advances when more words follow.
               if (im_we_q) begin
                  if (last_word) state_d   = ST_CSUM;
                  else           im_addr_d = im_addr_q + 1'b1;
               end
               if (byte_valid_q) begin
                  im_wdata_d[8*byte_idx_q +: 8] = shift_q;
                  csum_d     = csum_q ^ shift_q;
                  byte_idx_d = byte_idx_q + 2'd1;
                  if (byte_idx_q == 2'd3) im_we_d = 1'b1;
               end
            end
            ST_CSUM: begin
               if (byte_valid_q) state_d = (shift_q == csum_q) ? ST_DONE : ST_ERR;
            end
            default: state_d = ST_IDLE;
         endcase
      end

`ifdef UART_IM_LOADER_TIMEOUT_EN
      timed = (state_q == ST_LEN0) || (state_q == ST_LEN1) ||
              (state_q == ST_DATA) || (state_q == ST_CSUM);
      if (timed && !byte_valid_q && (state_d == state_q)) begin
         wdog_d = wdog_q + 1'b1;
         if (wdog_q == WD_W'(TO_CYCLES - 1)) state_d = ST_ERR;
      end
`endif

      // State-entry side effects
      if ((state_d == ST_SYNC) && (state_q != ST_SYNC)) begin
         cpu_rst_n_d = 1'b0;
         busy_d      = 1'b1;
         done_d      = 1'b0;
         err_d       = 1'b0;
         im_addr_d   = '0;
         csum_d      = 8'h00;
         byte_idx_d  = 2'd0;
      end
      if ((state_d == ST_DONE) && (state_q != ST_DONE)) begin
         cpu_rst_n_d = 1'b1;
         busy_d      = 1'b0;
         done_d      = 1'b1;
      end
      if ((state_d == ST_ERR) && (state_q != ST_ERR)) begin
         cpu_rst_n_d = 1'b0;
         busy_d      = 1'b0;
         err_d       = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_meta_q    <= 1'b1;
         rx_sync_q    <= 1'b1;
         rx_prev_q    <= 1'b1;
         start_meta_q <= 1'b0;
         start_sync_q <= 1'b0;
         start_prev_q <= 1'b0;
         rx_state_q   <= RX_IDLE;
         bit_cnt_q    <= '0;
         bit_idx_q    <= '0;
         shift_q      <= '0;
         byte_valid_q <= 1'b0;
         frame_err_q  <= 1'b0;
         state_q      <= ST_IDLE;
         len_q        <= '0;
         byte_idx_q   <= '0;
         csum_q       <= '0;
         im_we_q      <= 1'b0;
         im_addr_q    <= '0;
         im_wdata_q   <= '0;
         cpu_rst_n_q  <= 1'b1;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
`ifdef UART_IM_LOADER_TIMEOUT_EN
         wdog_q       <= '0;
`endif
      end else begin
         rx_meta_q    <= rx_meta_d;
         rx_sync_q    <= rx_sync_d;
         rx_prev_q    <= rx_prev_d;
         start_meta_q <= start_meta_d;
         start_sync_q <= start_sync_d;
         start_prev_q <= start_prev_d;
         rx_state_q   <= rx_state_d;
         bit_cnt_q    <= bit_cnt_d;
         bit_idx_q    <= bit_idx_d;
         shift_q      <= shift_d;
         byte_valid_q <= byte_valid_d;
         frame_err_q  <= frame_err_d;
         state_q      <= state_d;
         len_q        <= len_d;
         byte_idx_q   <= byte_idx_d;
         csum_q       <= csum_d;
         im_we_q      <= im_we_d;
         im_addr_q    <= im_addr_d;
         im_wdata_q   <= im_wdata_d;
         cpu_rst_n_q  <= cpu_rst_n_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         err_q        <= err_d;
`ifdef UART_IM_LOADER_TIMEOUT_EN
         wdog_q       <= wdog_d;
`endif
      end
   end

   assign im_we     = im_we_q;
   assign im_addr   = im_addr_q;
   assign im_wdata  = im_wdata_q;
   assign cpu_rst_n = cpu_rst_n_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign err       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_im_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_im_loader
// Purpose  : Self-checking bench for uart_im_loader. Expected IM writes are
//            queued as frames are sent; a monitor pops and compares on every
//            im_we strobe. Status outputs are checked after each frame.
//            10 clocks per bit (CLK_HZ=1 MHz, BAUD=100 kbaud).
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_im_loader;

   localparam int ADDR_W = 8;
   localparam int CPB    = 10;

   logic              clk;
   logic              rst_n;
   logic              rx;
   logic              start;
   logic              im_we;
   logic [ADDR_W-1:0] im_addr;
   logic [31:0]       im_wdata;
   logic              cpu_rst_n;
   logic              busy;
   logic              done;
   logic              err;

   int checks = 0;
   int errors = 0;

   logic [ADDR_W+31:0] exp_q[$];
   logic               we_prev = 1'b0;

   uart_im_loader #(
      .CLK_HZ      (1000000),
      .BAUD        (100000),
      .ADDR_W      (ADDR_W),
      .DEPTH_WORDS (256)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .rx        (rx),
      .start     (start),
      .im_we     (im_we),
      .im_addr   (im_addr),
      .im_wdata  (im_wdata),
      .cpu_rst_n (cpu_rst_n),
      .busy      (busy),
      .done      (done),
      .err       (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Write monitor: every strobe must match the head of the expected queue
   always @(negedge clk) begin
      if (rst_n && im_we) begin
         logic [ADDR_W+31:0] e;
         checks++;
         if (we_prev) begin
            errors++;
            $display("FAIL we_pulse_width: im_we high two cycles in a row");
         end
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write: addr=%h data=%h, required no write",
                     im_addr, im_wdata);
         end else begin
            e = exp_q.pop_front();
            if ({im_addr, im_wdata} !== e) begin
               errors++;
               $display("FAIL write: addr=%h data=%h, required addr=%h data=%h",
                        im_addr, im_wdata, e[ADDR_W+31:32], e[31:0]);
            end
         end
      end
      we_prev <= rst_n & im_we;
   end

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, required %h", name, act, req);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_bit);
      logic [7:0] v;
      v = b;
      @(negedge clk);
      rx = 1'b0;
      idle(CPB);
      for (int i = 0; i < 8; i++) begin
         rx = v[i];
         idle(CPB);
      end
      rx = stop_bit;
      idle(CPB);
      rx = 1'b1;
      idle(3);
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      idle(4);
      start = 1'b0;
      idle(4);
   endtask

   task automatic expect_write(input logic [ADDR_W-1:0] a, input logic [31:0] d);
      exp_q.push_back({a, d});
   endtask

   task automatic check_status(input string name, input logic b, input logic d,
                               input logic e, input logic c);
      check({name, "_busy"},      {31'd0, busy},      {31'd0, b});
      check({name, "_done"},      {31'd0, done},      {31'd0, d});
      check({name, "_err"},       {31'd0, err},       {31'd0, e});
      check({name, "_cpu_rst_n"}, {31'd0, cpu_rst_n}, {31'd0, c});
   endtask

   task automatic check_drained(input string name);
      check({name, "_pending_writes"}, exp_q.size(), 32'd0);
      exp_q.delete();
   endtask

   initial begin
      rst_n = 1'b0;
      rx    = 1'b1;
      start = 1'b0;
      idle(5);
      check_status("reset", 1'b0, 1'b0, 1'b0, 1'b1);
      check("reset_im_addr",  {24'd0, im_addr}, 32'd0);
      check("reset_im_wdata", im_wdata, 32'd0);
      rst_n = 1'b1;
      idle(50);
      check_status("idle", 1'b0, 1'b0, 1'b0, 1'b1);

      // Two-word frame; data bytes XOR to 13^B3^10 = B0
      pulse_start();
      check_status("armed", 1'b1, 1'b0, 1'b0, 1'b0);
      expect_write(8'd0, 32'h0000_0013);
      expect_write(8'd1, 32'h0010_00B3);
      send_byte(8'hA5, 1'b1);
      send_byte(8'h02, 1'b1);
      send_byte(8'h00, 1'b1);
      pulse_start();                       // ignored while busy
      send_byte(8'h13, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'hB3, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'h10, 1'b1);
      send_byte(8'h00, 1'b1);
      check("mid_busy", {31'd0, busy}, 32'd1);
      send_byte(8'hB0, 1'b1);
      check_status("good", 1'b0, 1'b1, 1'b0, 1'b1);
      check_drained("good");

      // Same frame, wrong checksum
      pulse_start();
      expect_write(8'd0, 32'h0000_0013);
      expect_write(8'd1, 32'h0010_00B3);
      send_byte(8'hA5, 1'b1);
      send_byte(8'h02, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'h13, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'hB3, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'h10, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'h00, 1'b1);
      check_status("bad_csum", 1'b0, 1'b0, 1'b1, 1'b0);
      check_drained("bad_csum");

      // N = 257 exceeds capacity: error after the length, no writes
      pulse_start();
      send_byte(8'hA5, 1'b1);
      send_byte(8'h01, 1'b1);
      send_byte(8'h01, 1'b1);
      check_status("too_long", 1'b0, 1'b0, 1'b1, 1'b0);
      check_drained("too_long");

      // N = 0: straight to checksum, expected 00
      pulse_start();
      send_byte(8'hA5, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'h00, 1'b1);
      check_status("empty", 1'b0, 1'b1, 1'b0, 1'b1);

      // Framing error in DATA
      pulse_start();
      send_byte(8'hA5, 1'b1);
      send_byte(8'h01, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'h13, 1'b0);
      check_status("frame_err", 1'b0, 1'b0, 1'b1, 1'b0);
      check_drained("frame_err");

      // 3-clock glitch in SYNC, then a valid one-word frame (csum 78^56^34^12=08)
      pulse_start();
      @(negedge clk);
      rx = 1'b0;
      idle(3);
      rx = 1'b1;
      idle(40);
      check("glitch_busy", {31'd0, busy}, 32'd1);
      expect_write(8'd0, 32'h1234_5678);
      send_byte(8'hA5, 1'b1);
      send_byte(8'h01, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'h78, 1'b1);
      send_byte(8'h56, 1'b1);
      send_byte(8'h34, 1'b1);
      send_byte(8'h12, 1'b1);
      send_byte(8'h08, 1'b1);
      check_status("glitch", 1'b0, 1'b1, 1'b0, 1'b1);
      check_drained("glitch");

      // Stall after the header
      pulse_start();
      send_byte(8'hA5, 1'b1);
      send_byte(8'h01, 1'b1);
      send_byte(8'h00, 1'b1);
      idle(250);
`ifdef UART_IM_LOADER_TIMEOUT_EN
      check_status("timeout", 1'b0, 1'b0, 1'b1, 1'b0);
`else
      check_status("stall", 1'b1, 1'b0, 1'b0, 1'b0);
      // AA^BB^CC^DD = 00
      expect_write(8'd0, 32'hDDCC_BBAA);
      send_byte(8'hAA, 1'b1);
      send_byte(8'hBB, 1'b1);
      send_byte(8'hCC, 1'b1);
      send_byte(8'hDD, 1'b1);
      send_byte(8'h00, 1'b1);
      check_status("resume", 1'b0, 1'b1, 1'b0, 1'b1);
`endif
      check_drained("final");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
